// File: rtl/apb_add_slave.sv
// rtl/apb_add_slave.sv - APB completer holding a 32-bit accumulator, sticky overflow flag and add counter
//
// Purpose:
//   Responder end of the add-master link. Serves a 16-byte register window at
//   BASE_ADDR on the APB bus:
//     0x0 ACC   r/w  read returns acc; write adds pwdata (mod 2^32), carry sets ovf,
//                    and the accepted-add counter increments
//     0x4 CTRL  r/w  read returns {31'b0, ovf}; write with bit0=1 clears acc and ovf
//     0x8 COUNT r/o  read returns the accepted-add counter, zero-extended
//     0xC, misaligned offsets and out-of-window addresses answer with pslverr
//   Each transfer may be stretched by WAIT_STATES access cycles with pready low.
//
// Ports:
//   pclk     in   APB clock, all state updates on the rising edge
//   preset   in   synchronous active-high reset
//   psel     in   slave select
//   penable  in   access phase
//   paddr    in   [31:0] byte address
//   pwrite   in   1 = write, 0 = read
//   pwdata   in   [31:0] write data
//   prdata   out  [31:0] read data, non-zero only on a completing good read
//   pready   out  transfer completion
//   pslverr  out  error response, only together with pready

module apb_add_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hA000,
    parameter int          WAIT_STATES = 0,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] OFF_ACC   = 4'h0;
    localparam logic [3:0] OFF_CTRL  = 4'h4;
    localparam logic [3:0] OFF_COUNT = 4'h8;

    state_t                 state_q, state_d;
    logic [3:0]             wait_q,  wait_d;
    logic [31:0]            acc_q,   acc_d;
    logic                   ovf_q,   ovf_d;
    logic [CNT_WIDTH-1:0]   cnt_q,   cnt_d;

    logic        in_window;
    logic [3:0]  offset;
    logic        access_err;
    logic        complete;
    logic [32:0] sum;
    logic [31:0] rd_value;

    // Address decode only looks at paddr/pwrite so the response is known
    // before the data phase ends; pwdata never reaches an output.
    always_comb begin
        in_window  = (paddr[31:4] == BASE_ADDR[31:4]);
        offset     = paddr[3:0];
        access_err = 1'b0;
        if (!in_window || (offset[1:0] != 2'b00)) begin
            access_err = 1'b1;
        end else begin
            case (offset)
                OFF_ACC:   access_err = 1'b0;
                OFF_CTRL:  access_err = 1'b0;
                OFF_COUNT: access_err = pwrite;
                default:   access_err = 1'b1;
            endcase
        end
    end

    always_comb begin
        rd_value = 32'h0;
        case (offset)
            OFF_ACC:   rd_value = acc_q;
            OFF_CTRL:  rd_value = {31'h0, ovf_q};
            OFF_COUNT: rd_value = 32'(cnt_q);
            default:   rd_value = 32'h0;
        endcase
    end

    // The completing cycle is the last ACCESS cycle with the wait counter
    // drained; reset forces it low so nothing is answered or committed.
    assign complete = !preset && (state_q == ACCESS) && psel && penable && (wait_q == 4'd0);

    assign pready  = complete;
    assign pslverr = complete && access_err;
    assign prdata  = (complete && !pwrite && !access_err) ? rd_value : 32'h0;

    // 33-bit sum so the carry-out into the sticky flag is explicit.
    assign sum = {1'b0, acc_q} + {1'b0, pwdata};

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                // A psel+penable sample without a setup phase is ignored.
                if (psel && !penable) begin
                    state_d = ACCESS;
                    wait_d  = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!psel) begin
                    // Master dropped the transfer: no commit, no response.
                    state_d = IDLE;
                    wait_d  = 4'd0;
                end else if (penable) begin
                    if (wait_q != 4'd0) begin
                        wait_d = wait_q - 4'd1;
                    end else begin
                        state_d = IDLE;
                        if (pwrite && !access_err) begin
                            case (offset)
                                OFF_ACC: begin
                                    acc_d = sum[31:0];
                                    ovf_d = ovf_q | sum[32];
                                    cnt_d = cnt_q + CNT_WIDTH'(1);
                                end
                                OFF_CTRL: begin
                                    if (pwdata[0]) begin
                                        acc_d = 32'h0;
                                        ovf_d = 1'b0;
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            acc_q   <= 32'h0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
